// File: rtl/instr_fetch_queue_if.sv
// Byte-stream input and instruction-issue bus of the fetch queue.
// The master side feeds bytes and permits issue; the slave side is the queue itself.
interface instr_fetch_queue_if #(
    parameter int ADDR_W = 2
);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_sync;
    logic              in_ready;
    logic              issue_en;
    logic [8:0]        instr_out;
    logic              instr_valid;
    logic [ADDR_W:0]   fifo_count;
    logic [7:0]        issued_count;
    logic              fmt_err;

    modport master (
        output in_byte, in_valid, in_sync, issue_en,
        input  in_ready, instr_out, instr_valid, fifo_count, issued_count, fmt_err
    );

    modport slave (
        input  in_byte, in_valid, in_sync, issue_en,
        output in_ready, instr_out, instr_valid, fifo_count, issued_count, fmt_err
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Pairs 8-bit pin bytes into 9-bit instructions, buffers them in a small FIFO
// and issues at most one per cycle with a single-cycle strobe.
module instr_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    instr_fetch_queue_if.slave bus
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {LO = 1'b0, HI = 1'b1} phase_t;

    phase_t            phase;
    logic [7:0]        lo_hold;
    logic [8:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [8:0]        instr_q;
    logic              vld_q;
    logic [7:0]        issued_q;
    logic              err_q;

    logic full, empty, pop, in_ready, accept, push;

    // A high byte may enter a full FIFO only when a pop frees a slot this same cycle.
    always_comb begin
        full     = (count == FULL_CNT);
        empty    = (count == '0);
        pop      = bus.issue_en && !empty;
        in_ready = (phase == LO) || bus.in_sync || !full || pop;
        accept   = bus.in_valid && in_ready;
        push     = accept && (phase == HI) && !bus.in_sync;
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= {bus.in_byte[0], lo_hold};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase    <= LO;
            lo_hold  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            instr_q  <= '0;
            vld_q    <= 1'b0;
            issued_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                if (phase == LO || bus.in_sync) begin
                    lo_hold <= bus.in_byte;
                    phase   <= HI;
                end else begin
                    phase <= LO;
                    if (bus.in_byte[7:1] != 7'd0)
                        err_q <= 1'b1;
                end
            end

            if (push)
                wr_ptr <= wr_ptr + 1'b1;

            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                instr_q  <= mem[rd_ptr];
                issued_q <= issued_q + 8'd1;
            end
            vld_q <= pop;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.instr_out    = instr_q;
    assign bus.instr_valid  = vld_q;
    assign bus.fifo_count   = count;
    assign bus.issued_count = issued_q;
    assign bus.fmt_err      = err_q;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: framing, back-pressure, resync,
// format error, reset and issue-counter wrap, with a strobe scoreboard.
module tb_instr_fetch_queue;
    logic CLK = 1'b0;
    logic RESET;

    instr_fetch_queue_if #(.ADDR_W(2)) bus ();

    instr_fetch_queue #(.DEPTH(4), .ADDR_W(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] exp_q[$];
    logic       mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Every strobe must match the oldest expected instruction.
    always @(negedge CLK) begin
        if (mon_en && !RESET && bus.instr_valid === 1'b1) begin
            if (exp_q.size() == 0)
                chk("unexpected_strobe", {23'd0, bus.instr_out}, 32'hFFFF);
            else
                chk("issue_order", {23'd0, bus.instr_out}, {23'd0, exp_q.pop_front()});
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic sync);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        bus.in_sync  = sync;
        forever begin
            @(negedge CLK);
            if (bus.in_ready === 1'b1) break;
            waited++;
            if (waited > 200) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
    endtask

    task automatic send_instr(input logic [8:0] v);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = v[7:0];
        hi = {7'd0, v[8]};
        exp_q.push_back(v);
        send_byte(lo, 1'b0);
        send_byte(hi, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        forever begin
            @(negedge CLK);
            if (exp_q.size() == 0 && bus.fifo_count == 0) break;
            n++;
            if (n > 200) break;
        end
        chk("drain_left", exp_q.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] base;
        bus.in_byte  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.issue_en = 1'b0;
        RESET        = 1'b1;
        tick();
        tick();
        do_reset();
        mon_en = 1'b1;

        @(negedge CLK);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_out", bus.instr_out, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_issued", bus.issued_count, 0);
        chk("rst_err", bus.fmt_err, 0);
        chk("rst_ready", bus.in_ready, 1);
        tick();

        // Basic pair with exact strobe timing.
        exp_q.push_back(9'h15A);
        bus.issue_en = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h5A;
        tick();
        bus.in_byte  = 8'h01;
        tick();
        bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("t1_n1_valid", bus.instr_valid, 0);
        chk("t1_n1_count", bus.fifo_count, 1);
        tick();
        @(negedge CLK);
        chk("t1_valid", bus.instr_valid, 1);
        chk("t1_out", bus.instr_out, 9'h15A);
        chk("t1_issued", bus.issued_count, 1);
        chk("t1_count", bus.fifo_count, 0);
        tick();
        @(negedge CLK);
        chk("t1_one_shot", bus.instr_valid, 0);
        tick();

        // Fill, stall the fifth high byte, release with a simultaneous pop.
        bus.issue_en = 1'b0;
        for (int i = 1; i <= 4; i++) send_instr(9'(i));
        exp_q.push_back(9'h005);
        @(negedge CLK);
        chk("full_count", bus.fifo_count, 4);
        tick();
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h05;
        @(negedge CLK);
        chk("full_lo_ready", bus.in_ready, 1);
        tick();
        bus.in_byte = 8'h00;
        @(negedge CLK);
        chk("full_hi_stall", bus.in_ready, 0);
        tick();
        @(negedge CLK);
        chk("full_hi_stall2", bus.in_ready, 0);
        chk("full_hold", bus.fifo_count, 4);
        tick();
        bus.issue_en = 1'b1;
        @(negedge CLK);
        chk("full_release", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("pushpop_count", bus.fifo_count, 4);
        chk("pushpop_valid", bus.instr_valid, 1);
        drain();
        chk("t2_issued", bus.issued_count, 6);

        // Pointer wrap: fill, then stream while full with issue enabled.
        bus.issue_en = 1'b0;
        for (int i = 0; i < 4; i++) send_instr(9'h100 + 9'(i * 17));
        bus.issue_en = 1'b1;
        for (int i = 4; i < 12; i++) send_instr(9'h100 + 9'(i * 17));
        drain();
        chk("wrap_issued", bus.issued_count, 18);

        // Resync discards the held low byte.
        base = bus.issued_count;
        exp_q.push_back(9'h033);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h00, 1'b0);
        drain();
        chk("sync_one_issue", bus.issued_count, 32'(base + 8'd1));
        chk("err_clear", bus.fmt_err, 0);

        // Bad high byte still pushes bit 0; error is sticky.
        exp_q.push_back(9'h144);
        send_byte(8'h44, 1'b0);
        send_byte(8'h03, 1'b0);
        drain();
        chk("err_set", bus.fmt_err, 1);
        send_instr(9'h0C3);
        drain();
        chk("err_sticky", bus.fmt_err, 1);

        // Reset mid-stream with three entries queued and a held low byte.
        bus.issue_en = 1'b0;
        for (int i = 0; i < 3; i++) send_instr(9'h0F0 + 9'(i));
        send_byte(8'h77, 1'b0);
        @(negedge CLK);
        chk("pre_rst_count", bus.fifo_count, 3);
        chk("pre_rst_ready", bus.in_ready, 1);
        tick();
        do_reset();
        @(negedge CLK);
        chk("rst2_count", bus.fifo_count, 0);
        chk("rst2_out", bus.instr_out, 0);
        chk("rst2_valid", bus.instr_valid, 0);
        chk("rst2_issued", bus.issued_count, 0);
        chk("rst2_err", bus.fmt_err, 0);
        chk("rst2_ready", bus.in_ready, 1);
        tick();

        // Phase must be LO after reset: 07 is a low byte.
        bus.issue_en = 1'b1;
        exp_q.push_back(9'h007);
        send_byte(8'h07, 1'b0);
        send_byte(8'h00, 1'b0);
        drain();
        chk("post_rst_issued", bus.issued_count, 1);

        // Issued counter wraps after 256 issues.
        for (int i = 0; i < 254; i++) send_instr(9'(i * 3 + 1));
        drain();
        chk("issued_255", bus.issued_count, 255);
        send_instr(9'h1E1);
        drain();
        chk("issued_wrap", bus.issued_count, 0);
        chk("wrap_err", bus.fmt_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Front-end stage upstream of the accumulator CPU core. It assembles 9-bit instructions from the 8-bit input-pin byte stream, using two bytes per instruction. Assembled instructions are buffered in a small FIFO. They are then issued one per cycle onto the core's `INSTRUCTION` bus, with a single-cycle strobe that drives the core's `write_en`.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of two, 2..16.
- `ADDR_W`, default 2: log2(`DEPTH`).

Ports:
- `CLK`  in  1  the block's single clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset, sampled on the rising edge of `CLK`.
- `in_byte`  in  8  input byte from the pins.
- `in_valid`  in  1  `in_byte` is valid this cycle.
- `in_sync`  in  1  marks `in_byte` as the low byte of a new instruction; realigns framing.
- `in_ready`  out  1  block accepts `in_byte` this cycle (combinational).
- `issue_en`  in  1  downstream permits an issue this cycle.
- `instr_out`  out  9  instruction to the core's `INSTRUCTION`; registered.
- `instr_valid`  out  1  one-cycle issue strobe to the core's `write_en`; registered.
- `fifo_count`  out  ADDR_W+1  number of entries currently held.
- `issued_count`  out  8  instructions issued; wraps modulo 256.
- `fmt_err`  out  1  sticky: a high byte had a nonzero bit in [7:1].

## Operation

Assembler:
- A 1-bit `phase` register: LO (0) or HI (1). A low-byte holding register, `lo_hold[7:0]`.
- Accept condition: `in_valid && in_ready`.
- `in_sync` high on an accepted byte: the byte is treated as the low byte regardless of `phase`. Any held low byte is discarded.
- Accept in LO (or with sync): `lo_hold <= in_byte`, `phase <= HI`.
- Accept in HI without sync:
  - push `{in_byte[0], lo_hold}` into the FIFO, `phase <= LO`;
  - if `in_byte[7:1] != 0`, set `fmt_err`. The entry is still pushed.
- `in_ready = (phase == LO) || in_sync || !full || pop`.
  - `pop` is the same-cycle issue condition below.
  - A low byte is always accepted.
  - A high byte is accepted only if FIFO space exists at the end of the cycle.
- `in_valid` low: `phase`, `lo_hold` and `fmt_err` hold. `in_sync` is ignored when `in_valid` is low.

FIFO:
- Circular buffer with `wr_ptr` and `rd_ptr` of `ADDR_W` bits each, wrapping `DEPTH-1` -> 0.
- `count` is `ADDR_W+1` bits; `full` = (`count == DEPTH`); `empty` = (`count == 0`).
- `pop = issue_en && !empty`.
- Push and pop in the same cycle, including when full: both pointers advance and `count` is unchanged.
- A push while full with no pop cannot occur, because `in_ready` is low.

Issue:
- `pop`: `instr_out <= mem[rd_ptr]`, `instr_valid <= 1`, `issued_count <= issued_count + 1` (255 -> 0).
- No `pop`: `instr_valid <= 0`; `instr_out` holds its last value.
- `issue_en` high while the FIFO is empty: no strobe, no count change.

Reset:
- The synchronous `RESET` has priority over every other input in that cycle. Any partially assembled instruction and all FIFO contents are discarded.
- After the reset edge:
  - `phase` = LO, `lo_hold` = 0, pointers = 0;
  - `fifo_count` = 0, `instr_out` = 9'h000, `instr_valid` = 0, `issued_count` = 0, `fmt_err` = 0;
  - `in_ready` = 1.
- FIFO memory contents need not be cleared.

## Timing

- High-byte accept at the edge ending cycle N:
  - entry visible, with `fifo_count` incremented, in cycle N+1;
  - with `issue_en` high in N+1, `instr_valid` = 1 and `instr_out` valid in cycle N+2.
- Minimum latency from high-byte handshake to strobe is 2 cycles. There is no bypass path.
- Sustained throughput: input is 1 instruction per 2 accepted bytes; output is up to 1 issue per cycle.
- `in_ready` depends combinationally on `phase`, `in_sync`, `count` and `issue_en`. There is no path from `in_valid` or `in_byte` to `in_ready`.
- `instr_valid` is never high for two cycles unless two pops occur in consecutive cycles.

## Test plan

- Reset, then bytes 8'h5A, 8'h01 with `issue_en` = 1 -> `instr_valid` is high exactly one cycle, 2 cycles after the second byte, with `instr_out` = 9'h15A; `issued_count` = 1.
- `issue_en` = 0, push 5 instructions (values 9'h001..9'h005), `DEPTH` = 4:
  - the 4th high byte is accepted, `fifo_count` = 4;
  - the 5th low byte is accepted, the 5th high byte stalls with `in_ready` = 0;
  - raise `issue_en` -> the stalled byte is accepted in the same cycle as the pop; issue order is 001..005.
- Full FIFO with a simultaneous push and pop -> `fifo_count` stays 4; pointer wrap is verified by 12 sequential instructions issued in order.
- Send low byte 8'hAA, then `in_sync` with 8'h33, then 8'h00 -> the single instruction issued is 9'h033; 8'hAA is discarded.
- High byte 8'h03 -> entry is 9'h1xx and `fmt_err` = 1, sticky until `RESET`.
- Assert `RESET` with 3 entries queued and `phase` = HI -> next cycle all outputs are at reset values and `in_ready` = 1; 256 issues wrap `issued_count` to 0.
